// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs the IAD/IDT/ACKI_n handshake and buffers
// fetched words in a DEPTH-entry FIFO. Optional same-cycle bypass when `IFQ_BYPASS_EN is defined.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic [31:0]              iad_o,
  output logic                     ireq_o,
  input  logic                     acki_ni,
  input  logic [31:0]              idt_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     deq_i,
  output logic                     inst_valid_o,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       mem_pc_q   [DEPTH];
  logic [31:0]       mem_word_q [DEPTH];

  logic        ack;
  logic        flush;
  logic        push_req;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc;
  logic        unused_redirect_lsbs;

  assign ack                  = ~acki_ni;
  assign redirect_pc          = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Transfer control: what the current edge does to the queue and the fetch PC.
  always_comb begin
    flush      = 1'b0;
    push_req   = 1'b0;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      StIdle: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
      end
      StFetch: begin
        if (ack && redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (ack) begin
          push_req   = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
      end
      StDiscard: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end
      end
      default: ;
    endcase
  end

`ifdef IFQ_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = (state_q == StFetch) && ack && !redirect_i && (count_q == '0);
  // A bypassed word consumed in the same cycle never enters the FIFO.
  assign push       = push_req && !(bypass_hit && deq_i);
`else
  assign push       = push_req;
`endif

  assign pop = deq_i && (count_q != '0) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (redirect_i || (count_d < DepthCnt)) state_d = StFetch;
      end
      StFetch: begin
        if (ack && !redirect_i) begin
          state_d = (count_d < DepthCnt) ? StFetch : StIdle;
        end else if (redirect_i && !ack) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (ack) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // The bus address may only move when no transfer is pending on it.
  always_comb begin
    bus_addr_d = bus_addr_q;
    if (!ireq_o || ack) bus_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      bus_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bus_addr_q <= bus_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= bus_addr_q;
      mem_word_q[wr_ptr_q] <= idt_i;
    end
  end

  assign ireq_o  = (state_q != StIdle);
  assign iad_o   = bus_addr_q;
  assign count_o = count_q;

  always_comb begin
    inst_valid_o = (count_q != '0);
    inst_o       = mem_word_q[rd_ptr_q];
    inst_pc_o    = mem_pc_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
    if (bypass_hit) begin
      inst_valid_o = 1'b1;
      inst_o       = idt_i;
      inst_pc_o    = bus_addr_q;
    end
`endif
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end: owns the fetch PC, drives the instruction bus (IAD/IDT/ACKI_n) with a wait-state-tolerant request/acknowledge handshake, and buffers fetched words in a DEPTH-entry FIFO in front of the IF/ID pipeline register. It replaces the fixed single-cycle fetch path. It adds variable memory latency, fetch-ahead buffering, and safe redirect while a bus transfer is outstanding.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- iad  out  32  instruction address bus
- ireq  out  1  fetch request, active high
- acki_n  in  1  instruction acknowledge, active low; idt valid in that cycle
- idt  in  32  instruction data bus
- redirect  in  1  branch/jump taken: flush queue, restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- deq  in  1  IF/ID consumes head entry this cycle
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction word
- inst_pc  out  32  address of head instruction
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc (next address to request), bus_addr (address on iad), FIFO storage {pc, word} × DEPTH, rd/wr pointers, count, 2-bit state.
- Reset values: state IDLE, fetch_pc = bus_addr = RESET_PC, count 0, pointers 0; outputs ireq 0, iad RESET_PC, inst_valid 0, count 0. inst/inst_pc undefined while inst_valid 0.
- Bus rule: once ireq is high, iad and ireq are held stable until an edge samples acki_n = 0; that edge completes the transfer. acki_n while ireq = 0 is ignored.
- IDLE: ireq 0. Redirect → fetch_pc = redirect_pc, flush, → FETCH. Otherwise → FETCH when count < DEPTH.
- FETCH: ireq 1, bus_addr = fetch_pc.
  - Ack, no redirect → push {bus_addr, idt}; fetch_pc += 4. → FETCH if post-update count < DEPTH, else IDLE.
  - Ack + redirect same edge → data dropped, flush, fetch_pc = redirect_pc, stay FETCH (new address next cycle).
  - Redirect without ack → flush, fetch_pc = redirect_pc, → DISCARD.
- DISCARD: ireq 1, iad holds stale address.
  - Ack → data dropped, → FETCH.
  - Further redirect → updates fetch_pc only.
- Queue:
  - Push and deq on the same edge → count unchanged.
  - deq while empty → ignored.
  - Redirect flushes: count 0, pointers equal. A deq in the same cycle is ignored.
  - Pointers wrap modulo DEPTH.
  - A push never occurs when full; the FSM guarantees space.
- fetch_pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset release to first ireq: ireq high after the first rising edge.
- Ack edge to inst_valid: 1 cycle (registered FIFO output), unless bypass is enabled.
- Redirect to new address on iad:
  - Next cycle if no transfer is outstanding or the ack coincides with the redirect.
  - Otherwise the cycle after the stale ack.
- Back-to-back zero-wait memory (acki_n held low): one instruction per cycle; sustained when deq is asserted every cycle.
- Asynchronous reset mid-transfer: ireq drops immediately. Memory must abandon the transfer.

## Configuration
- IFQ_BYPASS_EN defined:
  - When the queue is empty and an ack arrives in FETCH without redirect, inst_valid/inst/inst_pc are driven combinationally from idt/bus_addr in the same cycle.
  - If deq is also asserted, the word is not written and count stays 0.
- Not defined: outputs come only from FIFO registers, with 1-cycle ack-to-valid latency.

## Test plan
- Reset with RESET_PC = 0x100, acki_n tied low, deq high every cycle → iad 0x100, 0x104, 0x108…; inst_pc follows one cycle later; count ≤ 1.
- DEPTH = 4, acki_n low, deq low → four pushes, count = 4, ireq drops. A single deq → ireq re-asserts next cycle at 0x110.
- Two wait states (acki_n low on the third ireq cycle) → iad stable all three cycles; exactly one entry pushed.
- Redirect to 0x200 while a request to 0x108 is waiting:
  - DISCARD keeps iad = 0x108 until ack.
  - That word is dropped and count = 0.
  - Next iad = 0x200; first inst_pc = 0x200.
- Redirect coincident with ack and deq while count = 2 → count 0, iad = 0x200 next cycle, no stale entry surfaces.
- With IFQ_BYPASS_EN, empty queue, ack of 0x00000013 with deq → inst_valid and inst = 0x00000013 in the ack cycle; count stays 0.
